beta_mem_dump: RTL

Debug readback engine for the pipelined Beta core: on request it freezes the core, reads a window of words out of data memory, and streams them as a byte frame toward the UART transmitter. It is the hardware counterpart of the bench-side memory preload: the core's memory image goes out of the chip instead of being written in. It sits between the data-memory debug read port, the core's halt logic and the TX byte stream.

---
 rtl/beta_dump_pkg.sv | 18 +
 rtl/word_byte_serializer.sv | 48 ++++
 rtl/beta_mem_dump.sv | 133 +++++++++++++
 3 files changed

// File: rtl/beta_dump_pkg.sv
// Shared types and constants for the Beta memory dump engine.
// Holds the FSM state encoding, default frame sync byte and word size.
package beta_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_HDR,
    S_READ,
    S_WAIT_DATA,
    S_SEND,
    S_FINISH
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_byte_serializer.sv
// Splits a 32-bit word into 4 bytes, MSB first, over valid/ready.
// Ports: clk, i_rst_n (sync, active-low), i_load/i_word (load a word),
//        i_ready (sink accepts), o_valid/o_byte (current byte),
//        o_last (current byte is the final one of the word).
module word_byte_serializer
  import beta_dump_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [7:0]  o_byte,
  output logic        o_last
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      if (r_idx == LAST_IDX) begin
        r_valid <= 1'b0;
      end else begin
        r_shift <= {r_shift[23:0], 8'h00};
        r_idx   <= r_idx + 2'd1;
      end
    end
  end

  // Byte is forced to zero while idle so the shared TX mux idles at 0.
  assign o_valid = r_valid;
  assign o_byte  = r_valid ? r_shift[31:24] : 8'h00;
  assign o_last  = r_valid && (r_idx == LAST_IDX);

endmodule

// File: rtl/beta_mem_dump.sv
// Debug readback engine: halts the core, reads a window of data memory
// and streams it as a byte frame (sync byte + 4 bytes/word) toward TX.
// Ports: clk, RESET (sync, active-low); start/base_addr/word_count
//        request; busy/done status; halt_req/halt_ack core freeze;
//        mem_rd_en/mem_addr/mem_rdata memory read; tx_* byte stream.
module beta_mem_dump
  import beta_dump_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic              r_busy;
  logic              r_done;
  logic              r_halt;
  logic              r_rd;

  logic              w_ser_valid;
  logic [7:0]        w_ser_byte;
  logic              w_ser_last;
  logic              w_hdr;

  word_byte_serializer u_ser (
    .clk     (clk),
    .i_rst_n (RESET),
    .i_load  (r_state == S_WAIT_DATA),
    .i_word  (mem_rdata),
    .i_ready (tx_ready),
    .o_valid (w_ser_valid),
    .o_byte  (w_ser_byte),
    .o_last  (w_ser_last)
  );

  always_ff @(posedge clk) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_halt   <= 1'b0;
      r_rd     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_rd   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              r_addr   <= base_addr;
              r_remain <= word_count;
              r_busy   <= 1'b1;
              r_halt   <= 1'b1;
              r_state  <= S_HALT_WAIT;
            end else begin
              // Empty window: report completion without freezing.
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end
          end
        end
        S_HALT_WAIT: begin
          if (halt_ack) r_state <= S_HDR;
        end
        S_HDR: begin
          if (tx_ready) begin
            r_rd    <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_ser_last && tx_ready) begin
            if (r_remain == (ADDR_W+1)'(1)) begin
              r_busy  <= 1'b0;
              r_halt  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              // Address wraps modulo 2^ADDR_W by width.
              r_remain <= r_remain - (ADDR_W+1)'(1);
              r_addr   <= r_addr + ADDR_W'(1);
              r_rd     <= 1'b1;
              r_state  <= S_READ;
            end
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Header and payload bytes share one output mux.
  assign w_hdr     = (r_state == S_HDR);
  assign tx_valid  = w_hdr | w_ser_valid;
  assign tx_data   = w_hdr ? SYNC_BYTE : w_ser_byte;

  assign busy      = r_busy;
  assign done      = r_done;
  assign halt_req  = r_halt;
  assign mem_rd_en = r_rd;
  assign mem_addr  = r_addr;

endmodule
